reg_file_sb: RTL

Parametrised architectural register file for the RISC-V datapath.
- Configurable register count, data width and number of read ports.
- Hardwired zero register and same-cycle write-to-read bypass.
- Per-register busy scoreboard, so multi-cycle producers (loads, future mul/div) can mark a destination pending until writeback.
- Sits between decode (read addresses, issue) and writeback (write port).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/reg_read_port.sv | 39 +++
 rtl/reg_file_sb.sv | 91 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the architectural register file and its read ports.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREG_DEF  = 32;
  localparam int unsigned ZERO_ADDR = 0;

  // Low bit of lane k in a packed bus whose lanes are w bits wide.
  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: zero-register masking, write bypass and busy reporting.
module reg_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic [AW-1:0]   ra,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [XLEN-1:0] stored,
  input  logic            stored_busy,
  output logic [XLEN-1:0] rd,
  output logic            rd_busy
);

  logic is_zero;
  logic fwd;

  assign is_zero = (ZERO_REG != 0) && (ra == AW'(ZERO_ADDR));
  assign fwd     = (BYPASS != 0) && we && (wa == ra);

  // Forwarded data is by definition no longer pending, so busy drops with it.
  always_comb begin
    rd      = stored;
    rd_busy = stored_busy;
    if (is_zero) begin
      rd      = '0;
      rd_busy = 1'b0;
    end else if (fwd) begin
      rd      = wd;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file with optional hardwired zero, write bypass and busy scoreboard.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned AW       = $clog2(NREG),
  parameter int unsigned NRD      = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WE3,
  input  logic [AW-1:0]       A3,
  input  logic [XLEN-1:0]     WD3,
  input  logic [NRD*AW-1:0]   RA,
  output logic [NRD*XLEN-1:0] RD,
  output logic [NRD-1:0]      RD_BUSY,
  input  logic                SB_SET,
  input  logic [AW-1:0]       SB_A,
  output logic [NREG-1:0]     BUSY_VEC
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            wr_en;
  logic            we_fwd;

  assign wr_en  = WE3 && !((ZERO_REG != 0) && (A3 == AW'(ZERO_ADDR)));
  // Reset must win over the bypass so outputs read zero while RST is held.
  assign we_fwd = WE3 && !RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[A3] <= WD3;
    end
  end

  // Issue-time set beats writeback clear: the writeback belongs to an older producer.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if (SB_SET && (SB_A == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (WE3 && (A3 == AW'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      busy_d[ZERO_ADDR] = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign BUSY_VEC = busy_q;

  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [AW-1:0] ra_k;
    assign ra_k = RA[slice_lo(k, AW) +: AW];

    reg_read_port #(
      .XLEN    (XLEN),
      .AW      (AW),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .ra         (ra_k),
      .we         (we_fwd),
      .wa         (A3),
      .wd         (WD3),
      .stored     (regs_q[ra_k]),
      .stored_busy(busy_q[ra_k]),
      .rd         (RD[slice_lo(k, XLEN) +: XLEN]),
      .rd_busy    (RD_BUSY[k])
    );
  end

endmodule
